// File: rtl/pal_cfg_loader.sv
// ---------------------------------------------------------------------------
// pal_cfg_loader
//
// Purpose:
//   Streams one complete PAL configuration bitstream, received from a host
//   as bytes, into the serial CFG input of a PAL. The bitstream length is
//   L = 2*N*P + P*M bits. Bits are sent LSB first within each byte, and
//   bytes are sent in arrival order. After the last bit, the loader pulses
//   CFG_APPLY (the PAL EN input) and then pulses DONE.
//
// Parameters:
//   N  - number of PAL input variables
//   M  - number of PAL outputs
//   P  - number of PAL product stages
//
// Ports:
//   CLK        in   clock; all state changes on the rising edge
//   RES        in   synchronous active-high reset
//   START      in   request one full configuration stream (honoured in IDLE only)
//   DIN[7:0]   in   configuration byte from the host
//   DIN_VALID  in   DIN holds a valid byte
//   DIN_READY  out  the loader takes DIN this cycle (FETCH state)
//   CFG_OUT    out  serial configuration bit; 0 whenever CFG_SHIFT is 0
//   CFG_SHIFT  out  CFG_OUT is valid, and the PAL shifts one bit
//   CFG_APPLY  out  one-cycle strobe after the final bit
//   BUSY       out  high in every state except IDLE
//   DONE       out  one-cycle pulse in the cycle after CFG_APPLY
// ---------------------------------------------------------------------------
module pal_cfg_loader #(
    parameter int N = 8,
    parameter int M = 8,
    parameter int P = 16
) (
    input  logic       CLK,
    input  logic       RES,
    input  logic       START,
    input  logic [7:0] DIN,
    input  logic       DIN_VALID,
    output logic       DIN_READY,
    output logic       CFG_OUT,
    output logic       CFG_SHIFT,
    output logic       CFG_APPLY,
    output logic       BUSY,
    output logic       DONE
);

    localparam int L  = 2 * N * P + P * M;
    localparam int CW = $clog2(L + 1);
    localparam logic [CW-1:0] L_C = CW'(L);
    localparam logic [CW-1:0] ONE = CW'(1);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        SHIFT,
        APPLY
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;      // bits streamed since START was accepted
    logic [2:0]    r_bit;      // bit position within the current byte
    // Holds the bits of the current byte that have not yet reached CFG_OUT.
    // The bit being presented now lives in r_out, so only 7 bits remain here.
    logic [6:0]    r_shreg;
    logic          r_ready;
    logic          r_out;
    logic          r_shift;
    logic          r_apply;
    logic          r_busy;
    logic          r_done;

    logic [CW-1:0] w_cnt_nxt;
    logic          w_last;

    assign w_cnt_nxt = r_cnt + ONE;
    // The current bit is the last one of this SHIFT burst when it is either
    // bit 7 of the byte or the final bit of the whole stream. The second case
    // drops the unused upper bits of a partial final byte.
    assign w_last    = (r_bit == 3'd7) || (w_cnt_nxt == L_C);

    // Every output is registered. Each transition below sets the outputs
    // that belong to the state being entered.
    always_ff @(posedge CLK) begin
        if (RES) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shreg <= '0;
            r_ready <= 1'b0;
            r_out   <= 1'b0;
            r_shift <= 1'b0;
            r_apply <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (START) begin
                        r_cnt   <= '0;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= FETCH;
                    end
                end
                FETCH: begin
                    if (DIN_VALID) begin
                        r_out   <= DIN[0];
                        r_shreg <= DIN[7:1];
                        r_bit   <= '0;
                        r_shift <= 1'b1;
                        r_ready <= 1'b0;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_cnt   <= w_cnt_nxt;
                    r_bit   <= r_bit + 3'd1;
                    r_shreg <= {1'b0, r_shreg[6:1]};
                    if (w_last) begin
                        r_shift <= 1'b0;
                        r_out   <= 1'b0;
                        if (w_cnt_nxt < L_C) begin
                            r_ready <= 1'b1;
                            r_state <= FETCH;
                        end else begin
                            r_apply <= 1'b1;
                            r_state <= APPLY;
                        end
                    end else begin
                        r_out <= r_shreg[0];
                    end
                end
                APPLY: begin
                    r_apply <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign DIN_READY = r_ready;
    assign CFG_OUT   = r_out;
    assign CFG_SHIFT = r_shift;
    assign CFG_APPLY = r_apply;
    assign BUSY      = r_busy;
    assign DONE      = r_done;

endmodule

// File: tb/tb_pal_cfg_loader.sv
// ---------------------------------------------------------------------------
// tb_pal_cfg_loader
//
// Self-checking bench for pal_cfg_loader. It instantiates two loaders:
//   - u_main:  the default size, with L = 384
//   - u_small: N=1, M=1, P=3, with L = 9
// Both loaders share the same inputs, and the bench observes one of them per
// run. The expected bitstream is built directly from the source bytes
// (LSB first, bytes in order, truncated to L).
// ---------------------------------------------------------------------------
module tb_pal_cfg_loader;

    logic       CLK       = 1'b0;
    logic       RES       = 1'b0;
    logic       START     = 1'b0;
    logic [7:0] DIN       = 8'h00;
    logic       DIN_VALID = 1'b0;

    logic m_ready, m_out, m_shift, m_apply, m_busy, m_done;
    logic s_ready, s_out, s_shift, s_apply, s_busy, s_done;

    always #5 CLK = ~CLK;

    pal_cfg_loader u_main (
        .CLK(CLK), .RES(RES), .START(START), .DIN(DIN), .DIN_VALID(DIN_VALID),
        .DIN_READY(m_ready), .CFG_OUT(m_out), .CFG_SHIFT(m_shift),
        .CFG_APPLY(m_apply), .BUSY(m_busy), .DONE(m_done)
    );

    pal_cfg_loader #(.N(1), .M(1), .P(3)) u_small (
        .CLK(CLK), .RES(RES), .START(START), .DIN(DIN), .DIN_VALID(DIN_VALID),
        .DIN_READY(s_ready), .CFG_OUT(s_out), .CFG_SHIFT(s_shift),
        .CFG_APPLY(s_apply), .BUSY(s_busy), .DONE(s_done)
    );

    // Select which loader the current run observes.
    logic sel = 1'b0;
    logic o_ready, o_out, o_shift, o_apply, o_busy, o_done;
    assign o_ready = sel ? s_ready : m_ready;
    assign o_out   = sel ? s_out   : m_out;
    assign o_shift = sel ? s_shift : m_shift;
    assign o_apply = sel ? s_apply : m_apply;
    assign o_busy  = sel ? s_busy  : m_busy;
    assign o_done  = sel ? s_done  : m_done;

    int checks = 0;
    int errors = 0;

    logic [7:0] src [64];
    bit         got [$];
    int         acc [$];
    int pulses, first_shift, last_shift, apply_cyc, done_cyc;
    int n_apply, n_done, busy_done, lat_err, zero_err, excl_err;
    int res_cyc, res_outs, timed_out;

    typedef struct {
        int seed;
        int gap_len;
        int start_a;
        int start_b;
        int exp_pulses;
        int exp_apply;
        int exp_done;
    } vec_t;

    vec_t tbl [4];

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, req);
        end
    endtask

    task automatic fill(input int seed);
        src[0] = 8'hA5;
        for (int i = 1; i < 64; i++) begin
            int v;
            v      = (i * 37 + seed * 11) ^ 'h5A;
            src[i] = v[7:0];
        end
    endtask

    // Runs one stream against the selected loader while acting as the host.
    // START is asserted in cycle 0. A gap holds DIN_VALID low for gap_len
    // FETCH cycles before byte gap_byte. A value of res_bit >= 0 pulses RES
    // once that many bits have been seen. When rnd_pct > 0, DIN_VALID and
    // the extra START pulses are random.
    task automatic run(input bit which, input int gap_byte, input int gap_len,
                       input int start_a, input int start_b, input int res_bit,
                       input int rnd_pct, input bit pre_reset);
        int idx, gapc, stop_at;
        bit v;
        sel = which;
        if (pre_reset) begin
            RES = 1'b1; START = 1'b0; DIN_VALID = 1'b0;
            @(posedge CLK); #1;
            RES = 1'b0;
        end
        got.delete(); acc.delete();
        pulses = 0; first_shift = -1; last_shift = -1; apply_cyc = -1; done_cyc = -1;
        n_apply = 0; n_done = 0; busy_done = -1; lat_err = 0; zero_err = 0; excl_err = 0;
        res_cyc = -1; res_outs = -1; timed_out = 1;
        idx = 0; gapc = 0; stop_at = -1;
        for (int c = 0; c < 3000; c++) begin
            if (o_shift) begin
                if (first_shift < 0) first_shift = c;
                last_shift = c;
                if (pulses / 8 < acc.size()) begin
                    if (c != acc[pulses / 8] + 1 + pulses % 8) lat_err++;
                end else begin
                    lat_err++;
                end
                got.push_back(o_out);
                pulses++;
            end else if (o_out) begin
                zero_err++;
            end
            if ((int'(o_ready) + int'(o_shift) + int'(o_apply)) > 1 ||
                ((o_ready || o_shift || o_apply) && !o_busy))
                excl_err++;
            if (o_apply) begin n_apply++; apply_cyc = c; end
            if (o_done) begin
                n_done++; done_cyc = c; busy_done = int'(o_busy);
                if (stop_at < 0) stop_at = c + 3;
            end
            if (res_cyc >= 0 && c == res_cyc + 1)
                res_outs = int'({o_ready, o_out, o_shift, o_apply, o_busy, o_done});
            if (c == stop_at) begin
                timed_out = 0;
                break;
            end
            RES = 1'b0;
            if (res_bit >= 0 && res_cyc < 0 && pulses == res_bit) begin
                RES = 1'b1; res_cyc = c; stop_at = c + 20;
            end
            START = (c == 0) || (c == start_a) || (c == start_b) ||
                    (rnd_pct > 0 && c > 0 && n_done == 0 && $urandom_range(9) == 0);
            if (rnd_pct > 0) v = ($urandom_range(99) < rnd_pct);
            else             v = !(idx == gap_byte && gapc < gap_len);
            DIN_VALID = v;
            DIN       = src[idx & 63];
            if (o_ready && v) begin
                acc.push_back(c);
                idx++;
            end else if (o_ready && idx == gap_byte) begin
                gapc++;
            end
            @(posedge CLK); #1;
        end
        START = 1'b0; DIN_VALID = 1'b0; RES = 1'b0;
        chk("run_completed", timed_out, 0);
    endtask

    // Compare the observed stream with the reference built from src[].
    task automatic check_stream(input string tag, input int lx,
                                input int exp_apply, input int exp_done);
        int bad = 0;
        for (int b = 0; b < got.size() && b < lx; b++)
            if (got[b] !== src[b / 8][b % 8]) bad++;
        chk($sformatf("%s pulses", tag), pulses, lx);
        chk($sformatf("%s bit_errors", tag), bad, 0);
        chk($sformatf("%s n_apply", tag), n_apply, 1);
        chk($sformatf("%s n_done", tag), n_done, 1);
        chk($sformatf("%s apply_cycle", tag), apply_cyc,
            (exp_apply >= 0) ? exp_apply : last_shift + 1);
        chk($sformatf("%s done_cycle", tag), done_cyc,
            (exp_done >= 0) ? exp_done : apply_cyc + 1);
        chk($sformatf("%s busy_at_done", tag), busy_done, 0);
        chk($sformatf("%s latency_errors", tag), lat_err, 0);
        chk($sformatf("%s out_zero_errors", tag), zero_err, 0);
        chk($sformatf("%s exclusivity_errors", tag), excl_err, 0);
    endtask

    initial begin
        int fb;

        tbl[0] = '{1, 0, -1,  -1, 384, 433, 434};
        tbl[1] = '{2, 5, -1,  -1, 384, 438, 439};
        tbl[2] = '{3, 0, 50, 300, 384, 433, 434};
        tbl[3] = '{4, 5, 20, 438, 384, 438, 439};

        // Reset has priority over START in the same cycle.
        RES = 1'b1; START = 1'b1; DIN_VALID = 1'b1;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        chk("reset main outputs", int'({m_ready, m_out, m_shift, m_apply, m_busy, m_done}), 0);
        chk("reset small outputs", int'({s_ready, s_out, s_shift, s_apply, s_busy, s_done}), 0);
        RES = 1'b0; START = 1'b0; DIN_VALID = 1'b0;
        @(posedge CLK); #1;
        chk("idle after reset busy", int'(m_busy), 0);

        // Full streams: gaps and ignored START pulses.
        for (int t = 0; t < 4; t++) begin
            fill(tbl[t].seed);
            run(1'b0, 2, tbl[t].gap_len, tbl[t].start_a, tbl[t].start_b, -1, 0, 1'b1);
            check_stream($sformatf("vec%0d", t), tbl[t].exp_pulses,
                         tbl[t].exp_apply, tbl[t].exp_done);
            fb = 0;
            for (int i = 0; i < 8 && i < got.size(); i++) fb |= int'(got[i]) << i;
            chk($sformatf("vec%0d bitorder_A5", t), fb, 'hA5);
            chk($sformatf("vec%0d first_shift_cycle", t), first_shift, 2);
        end

        // Reset after 100 bits: abandon the stream, then recover.
        fill(7);
        run(1'b0, -1, 0, -1, -1, 100, 0, 1'b1);
        chk("midreset outputs", res_outs, 0);
        chk("midreset pulses", pulses, 100);
        chk("midreset n_apply", n_apply, 0);
        chk("midreset n_done", n_done, 0);
        fill(8);
        run(1'b0, -1, 0, -1, -1, -1, 0, 1'b0);
        check_stream("after_reset", 384, 433, 434);

        // Partial last byte with L = 9.
        for (int i = 0; i < 64; i++) src[i] = 8'h00;
        src[0] = 8'hFF; src[1] = 8'hFF;
        run(1'b1, -1, 0, -1, -1, -1, 0, 1'b1);
        check_stream("small_FF", 9, 12, 13);

        // Randomized bytes, DIN_VALID, and START pulses while busy.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 64; i++) src[i] = 8'($urandom);
            run(1'b0, -1, 0, -1, -1, -1, 75, 1'b1);
            check_stream($sformatf("rnd_main%0d", r), 384, -1, -1);
        end
        for (int i = 0; i < 64; i++) src[i] = 8'($urandom);
        run(1'b1, -1, 0, -1, -1, -1, 60, 1'b1);
        check_stream("rnd_small", 9, -1, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pal_cfg_loader.md
PAL_CFG_LOADER -- requirements
Module: pal_cfg_loader

Interface
REQ-001 SHALL have parameter N, default 8: number of PAL input variables.
REQ-002 SHALL have parameter M, default 8: number of PAL outputs.
REQ-003 SHALL have parameter P, default 16: number of PAL intermediate (product) stages.
REQ-004 SHALL have one clock; reset is synchronous and active-high.
REQ-005 SHALL have port CLK  input  1  clock; all state changes on its rising edge.
REQ-006 SHALL have port RES  input  1  synchronous active-high reset.
REQ-007 SHALL have port START  input  1  request to stream one complete configuration.
REQ-008 SHALL have port DIN  input  8  configuration byte from host.
REQ-009 SHALL have port DIN_VALID  input  1  DIN holds a valid byte.
REQ-010 SHALL have port DIN_READY  output  1  loader accepts DIN this cycle.
REQ-011 SHALL have port CFG_OUT  output  1  serial configuration bit to the PAL CFG input.
REQ-012 SHALL have port CFG_SHIFT  output  1  CFG_OUT valid; PAL shifts one bit this cycle.
REQ-013 SHALL have port CFG_APPLY  output  1  one-cycle strobe driving PAL EN after the last bit.
REQ-014 SHALL have port BUSY  output  1  high in every non-IDLE state.
REQ-015 SHALL have port DONE  output  1  one-cycle pulse after CFG_APPLY.

Function
REQ-016 SHALL stream L = 2*N*P + P*M bits per configuration (N=8, M=8, P=16: L = 384, 48 bytes); bit counter width clog2(L+1).
REQ-017 SHALL implement states IDLE, FETCH, SHIFT, APPLY.
REQ-018 IDLE: when START=1, SHALL clear the bit counter and enter FETCH on the next edge.
REQ-019 FETCH: SHALL assert DIN_READY=1; on DIN_VALID=1, SHALL capture DIN into the shift register and enter SHIFT.
REQ-020 FETCH: while DIN_VALID=0, SHALL hold FETCH indefinitely, with no timeout.
REQ-021 SHIFT: every cycle SHALL drive CFG_SHIFT=1 and CFG_OUT=shreg[0], then shift the register right and increment the bit counter.
REQ-022 Bit order SHALL be LSB first within a byte and bytes in arrival order; the first bit streamed is DIN[0] of the first byte.
REQ-023 SHALL leave SHIFT after 8 bits or when the counter reaches L, whichever comes first.
REQ-024 On leaving SHIFT, SHALL go to FETCH if the counter is below L, otherwise to APPLY.
REQ-025 If L mod 8 != 0, SHALL shift only the low (L mod 8) bits of the final byte and discard the upper bits.
REQ-026 Latency: a byte accepted in cycle k SHALL produce bits in cycles k+1..k+8.
REQ-027 DIN_READY SHALL reassert in cycle k+9, giving a throughput of 9 cycles per byte.
REQ-028 APPLY: SHALL assert CFG_APPLY=1 for exactly one cycle, then return to IDLE.
REQ-029 DONE SHALL be 1 in the cycle after APPLY only.
REQ-030 When CFG_SHIFT=0, CFG_OUT SHALL be 0.
REQ-031 DIN_READY SHALL be 0 outside FETCH, and DIN_VALID SHALL be ignored there.
REQ-032 START outside IDLE SHALL be ignored, with no restart and no queuing.
REQ-033 START=1 in the cycle DONE=1 (state IDLE) SHALL begin a new stream normally.
REQ-034 CFG_APPLY SHALL never assert unless exactly L CFG_SHIFT pulses occurred since the last START acceptance.

Reset
REQ-035 With RES=1 at an edge, state SHALL be IDLE and the bit counter and shift register 0.
REQ-036 With RES=1 at an edge, DIN_READY, CFG_OUT, CFG_SHIFT, CFG_APPLY, BUSY and DONE SHALL all be 0.
REQ-037 Reset SHALL take priority over all other inputs, including START in the same cycle.
REQ-038 Reset mid-stream SHALL abandon the partial stream with no CFG_APPLY or DONE; the next START restarts from bit 0.

Verification
REQ-039 Bench SHALL cover full stream: N=8, M=8, P=16, START at cycle 0, DIN_VALID held 1 -> 384 CFG_SHIFT pulses, CFG_APPLY at cycle 433, DONE at cycle 434, BUSY low from cycle 434.
REQ-040 Bench SHALL cover bit order: first byte 8'hA5 -> CFG_OUT sequence 1,0,1,0,0,1,0,1 in cycles 2..9.
REQ-041 Bench SHALL cover backpressure: DIN_VALID low for 5 cycles before byte 3 -> FETCH held, no CFG_SHIFT during the gap, total bit count still 384.
REQ-042 Bench SHALL cover partial last byte: N=1, M=1, P=3 (L=9), bytes 8'hFF, 8'hFF -> exactly 9 CFG_SHIFT pulses, then CFG_APPLY.
REQ-043 Bench SHALL cover reset mid-operation: RES pulsed after 100 bits -> all outputs 0 the next cycle, no CFG_APPLY; a new START yields a complete 384-bit stream.
REQ-044 Bench SHALL cover START while BUSY: START pulsed during SHIFT -> no effect on bit count or state sequence.
